regex_job_sequencer: RTL and testbench

//  Host-side initiator for the coprocessor command/status register interface: it drives cmd/address/data registers
//  and polls status/data_o registers. It accepts one job descriptor plus a stream of 64-bit program words, loads them

---
 rtl/regex_job_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_regex_job_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regex_job_sequencer.sv
// Host-side sequencer for the regex coprocessor register interface: loads a program,
// starts a run, waits for a terminal status, reads elapsed clocks, restarts, reports.
module regex_job_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned TIMEOUT_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    localparam int unsigned REG_WIDTH     = 32,
    localparam int unsigned REG_WIDTH_64  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ADDR_WIDTH:0]     job_word_count,
    input  logic [ADDR_WIDTH-1:0]   job_base_addr,
    input  logic [REG_WIDTH-1:0]    job_start_cc,
    input  logic [REG_WIDTH-1:0]    job_end_cc,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic [WORD_WIDTH-1:0]   word_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [1:0]              res_code,
    output logic [REG_WIDTH_64-1:0] res_elapsed,
    output logic                    busy,
    output logic [REG_WIDTH-1:0]    cmd_register,
    output logic [REG_WIDTH-1:0]    address_register,
    output logic [REG_WIDTH_64-1:0] data_in_register,
    output logic [REG_WIDTH-1:0]    start_cc_pointer_register,
    output logic [REG_WIDTH-1:0]    end_cc_pointer_register,
    input  logic [REG_WIDTH-1:0]    status_register,
    input  logic [REG_WIDTH_64-1:0] data_o_register
);

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd5;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [TIMEOUT_WIDTH-1:0] WdogLimit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StStart, StRun, StReset, StReadCc, StRestart, StWaitIdle, StResult
    } state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [TIMEOUT_WIDTH-1:0]  wdog_q, wdog_d;
    logic [REG_WIDTH-1:0]      cmd_q, cmd_d;
    logic [REG_WIDTH-1:0]      addr_q, addr_d;
    logic [REG_WIDTH_64-1:0]   data_q, data_d;
    logic [REG_WIDTH-1:0]      scc_q, scc_d;
    logic [REG_WIDTH-1:0]      ecc_q, ecc_d;
    logic [1:0]                code_q, code_d;
    logic [REG_WIDTH_64-1:0]   elapsed_q, elapsed_d;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic                      word_hs;

    assign word_ready = (state_q == StLoad) && (remaining_q != '0);
    assign word_hs    = word_valid && word_ready;
    // Modulo-2^ADDR_WIDTH so a load that runs off the top wraps to address 0.
    assign wr_addr    = base_q + idx_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        base_d      = base_q;
        wdog_d      = wdog_q;
        cmd_d       = CMD_NOP;
        addr_d      = addr_q;
        data_d      = data_q;
        scc_d       = scc_q;
        ecc_d       = ecc_q;
        code_d      = code_q;
        elapsed_d   = elapsed_q;

        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    remaining_d = job_word_count;
                    base_d      = job_base_addr;
                    idx_d       = '0;
                    scc_d       = job_start_cc;
                    ecc_d       = job_end_cc;
                    state_d     = (job_word_count != '0) ? StLoad : StStart;
                end
            end
            StLoad: begin
                if (word_hs) begin
                    cmd_d       = CMD_WRITE;
                    addr_d      = REG_WIDTH'(wr_addr);
                    data_d      = REG_WIDTH_64'(word_data);
                    idx_d       = idx_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CntW'(1);
                    if (remaining_q == CntW'(1)) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                cmd_d = CMD_START;
                // Only trust a non-idle status once START has actually been on the bus.
                if (cmd_q == CMD_START && status_register != STATUS_IDLE) begin
                    cmd_d   = CMD_NOP;
                    wdog_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (TIMEOUT_CYCLES != 0) begin
                    wdog_d = wdog_q + TIMEOUT_WIDTH'(1);
                end
                case (status_register)
                    STATUS_ACCEPTED: begin
                        code_d  = 2'd0;
                        cmd_d   = CMD_READ_ELAPSED_CLOCK;
                        state_d = StReadCc;
                    end
                    STATUS_REJECTED: begin
                        code_d  = 2'd1;
                        cmd_d   = CMD_READ_ELAPSED_CLOCK;
                        state_d = StReadCc;
                    end
                    STATUS_ERROR: begin
                        code_d  = 2'd2;
                        cmd_d   = CMD_READ_ELAPSED_CLOCK;
                        state_d = StReadCc;
                    end
                    default: begin
                        if (TIMEOUT_CYCLES != 0 && wdog_q == WdogLimit) begin
                            code_d    = 2'd3;
                            elapsed_d = REG_WIDTH_64'(wdog_q) + REG_WIDTH_64'(1);
                            cmd_d     = CMD_RESET;
                            state_d   = StReset;
                        end
                    end
                endcase
            end
            StReset: begin
                state_d = StResult;
            end
            StReadCc: begin
                // data_o_register is combinational from cmd, so it is valid this cycle.
                elapsed_d = data_o_register;
                cmd_d     = CMD_RESTART;
                state_d   = StRestart;
            end
            StRestart: begin
                state_d = StWaitIdle;
            end
            StWaitIdle: begin
                if (status_register == STATUS_IDLE) begin
                    state_d = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            wdog_q      <= '0;
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            scc_q       <= '0;
            ecc_q       <= '0;
            code_q      <= '0;
            elapsed_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            wdog_q      <= wdog_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            scc_q       <= scc_d;
            ecc_q       <= ecc_d;
            code_q      <= code_d;
            elapsed_q   <= elapsed_d;
        end
    end

    assign job_ready                 = (state_q == StIdle);
    assign res_valid                 = (state_q == StResult);
    assign busy                      = (state_q != StIdle);
    assign res_code                  = code_q;
    assign res_elapsed               = elapsed_q;
    assign cmd_register              = cmd_q;
    assign address_register          = addr_q;
    assign data_in_register          = data_q;
    assign start_cc_pointer_register = scc_q;
    assign end_cc_pointer_register   = ecc_q;

endmodule

// File: tb/tb_regex_job_sequencer.sv
// Directed bench for regex_job_sequencer with a behavioural coprocessor stub and a
// command-bus monitor; expectations are hand-computed constants.
module tb_regex_job_sequencer;

    localparam int unsigned AW = 9;

    localparam logic [31:0] CMD_NOP     = 32'd0;
    localparam logic [31:0] CMD_WRITE   = 32'd1;
    localparam logic [31:0] CMD_START   = 32'd2;
    localparam logic [31:0] CMD_READ    = 32'd3;
    localparam logic [31:0] CMD_RESTART = 32'd4;
    localparam logic [31:0] CMD_RESET   = 32'd5;
    localparam logic [31:0] ST_IDLE     = 32'd0;
    localparam logic [31:0] ST_RUNNING  = 32'd1;
    localparam logic [31:0] ST_ACCEPTED = 32'd2;
    localparam logic [31:0] ST_ERROR    = 32'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid, job_ready;
    logic [AW:0]   job_word_count;
    logic [AW-1:0] job_base_addr;
    logic [31:0]   job_start_cc, job_end_cc;
    logic          word_valid, word_ready;
    logic [63:0]   word_data;
    logic          res_valid, res_ready;
    logic [1:0]    res_code;
    logic [63:0]   res_elapsed;
    logic          busy;
    logic [31:0]   cmd_register, address_register, start_cc_pointer_register;
    logic [31:0]   end_cc_pointer_register, status_register;
    logic [63:0]   data_in_register, data_o_register;

    always #5 clk = ~clk;

    regex_job_sequencer #(
        .ADDR_WIDTH    (AW),
        .WORD_WIDTH    (64),
        .TIMEOUT_WIDTH (32),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .job_valid                (job_valid),
        .job_ready                (job_ready),
        .job_word_count           (job_word_count),
        .job_base_addr            (job_base_addr),
        .job_start_cc             (job_start_cc),
        .job_end_cc               (job_end_cc),
        .word_valid               (word_valid),
        .word_ready               (word_ready),
        .word_data                (word_data),
        .res_valid                (res_valid),
        .res_ready                (res_ready),
        .res_code                 (res_code),
        .res_elapsed              (res_elapsed),
        .busy                     (busy),
        .cmd_register             (cmd_register),
        .address_register         (address_register),
        .data_in_register         (data_in_register),
        .start_cc_pointer_register(start_cc_pointer_register),
        .end_cc_pointer_register  (end_cc_pointer_register),
        .status_register          (status_register),
        .data_o_register          (data_o_register)
    );

    // Coprocessor stub: RUNNING for stub_run_len cycles after START, then stub_term.
    int          stub_run_len;
    logic [31:0] stub_term;
    logic [63:0] stub_elapsed;
    int          run_cnt;

    always @(posedge clk) begin
        if (rst) begin
            status_register <= ST_IDLE;
            run_cnt         <= 0;
        end else if (cmd_register == CMD_RESTART || cmd_register == CMD_RESET) begin
            status_register <= ST_IDLE;
        end else if (cmd_register == CMD_START && status_register == ST_IDLE) begin
            status_register <= ST_RUNNING;
            run_cnt         <= 0;
        end else if (status_register == ST_RUNNING) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt + 1 == stub_run_len) status_register <= stub_term;
        end
    end

    assign data_o_register = (cmd_register == CMD_READ) ? stub_elapsed : 64'h0;

    // Command-bus monitor with cumulative counters.
    int          wr_cnt = 0, b2b_cnt = 0, start_bursts = 0, restart_cnt = 0, reset_cnt = 0;
    int          nop_since_start = 0, nop_at_reset = 0;
    logic [31:0] prev_cmd = 32'd0;
    logic [31:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_register == CMD_WRITE) begin
                wr_cnt <= wr_cnt + 1;
                wr_addr_q.push_back(address_register);
                wr_data_q.push_back(data_in_register);
                if (prev_cmd == CMD_WRITE) b2b_cnt <= b2b_cnt + 1;
            end
            if (cmd_register == CMD_START) begin
                nop_since_start <= 0;
                if (prev_cmd != CMD_START) start_bursts <= start_bursts + 1;
            end
            if (cmd_register == CMD_NOP) nop_since_start <= nop_since_start + 1;
            if (cmd_register == CMD_RESET) begin
                reset_cnt    <= reset_cnt + 1;
                nop_at_reset <= nop_since_start;
            end
            if (cmd_register == CMD_RESTART) restart_cnt <= restart_cnt + 1;
            prev_cmd <= cmd_register;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_job(input logic [AW:0] cnt, input logic [AW-1:0] base,
                            input logic [31:0] scc, input logic [31:0] ecc);
        int n = 0;
        job_valid      = 1'b1;
        job_word_count = cnt;
        job_base_addr  = base;
        job_start_cc   = scc;
        job_end_cc     = ecc;
        while (!job_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("job_accept_timeout", {63'd0, job_ready}, 64'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic put_words(input int cnt, input int gap, input logic [63:0] pat);
        for (int i = 0; i < cnt; i++) begin
            for (int g = 0; g < gap; g++) begin
                word_valid = 1'b0;
                @(negedge clk);
            end
            word_valid = 1'b1;
            word_data  = pat + 64'(i);
            begin
                int n = 0;
                while (!word_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("word_accept_timeout", {63'd0, word_ready}, 64'd1);
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_timeout", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("job_ready_after_res", {63'd0, job_ready}, 64'd1);
        check("res_valid_after_res", {63'd0, res_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] exp_addr1 [3];
        int wr0, b2b0, st0, rs0, rt0, n;
        exp_addr1 = '{32'h1FE, 32'h1FF, 32'h000};

        rst = 1'b1;
        job_valid = 1'b0; job_word_count = '0; job_base_addr = '0;
        job_start_cc = '0; job_end_cc = '0;
        word_valid = 1'b0; word_data = '0; res_ready = 1'b0;
        stub_run_len = 10; stub_term = ST_ACCEPTED; stub_elapsed = 64'd10;
        repeat (3) @(negedge clk);

        check("rst_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check("rst_addr", 64'(address_register), 64'd0);
        check("rst_data", data_in_register, 64'd0);
        check("rst_scc", 64'(start_cc_pointer_register), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_job_ready", {63'd0, job_ready}, 64'd1);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_word_ready", {63'd0, word_ready}, 64'd0);
        check("rst_res_elapsed", res_elapsed, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Job 1: three back-to-back words wrapping past the top of program memory.
        wr0 = wr_cnt; st0 = start_bursts; rt0 = restart_cnt;
        send_job(10'd3, 9'h1FE, 32'h11, 32'h22);
        put_words(3, 0, 64'hA5A5_0000_0000_0000);
        wait_res();
        check("j1_wr_count", 64'(wr_cnt - wr0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("j1_wr_addr", 64'(wr_addr_q[wr0 + i]), 64'(exp_addr1[i]));
            check("j1_wr_data", wr_data_q[wr0 + i], 64'hA5A5_0000_0000_0000 + 64'(i));
        end
        check("j1_start_once", 64'(start_bursts - st0), 64'd1);
        check("j1_restart_once", 64'(restart_cnt - rt0), 64'd1);
        check("j1_code", 64'(res_code), 64'd0);
        check("j1_elapsed", res_elapsed, 64'd10);
        check("j1_scc", 64'(start_cc_pointer_register), 64'h11);
        check("j1_ecc", 64'(end_cc_pointer_register), 64'h22);
        take_res();

        // Job 2: four words offered one cycle in three.
        wr0 = wr_cnt; b2b0 = b2b_cnt;
        stub_run_len = 3; stub_term = ST_ACCEPTED; stub_elapsed = 64'd7;
        send_job(10'd4, 9'h010, 32'h33, 32'h44);
        put_words(4, 2, 64'h0000_0000_CAFE_0000);
        wait_res();
        check("j2_wr_count", 64'(wr_cnt - wr0), 64'd4);
        check("j2_no_b2b_write", 64'(b2b_cnt - b2b0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("j2_wr_addr", 64'(wr_addr_q[wr0 + i]), 64'h10 + 64'(i));
            check("j2_wr_data", wr_data_q[wr0 + i], 64'h0000_0000_CAFE_0000 + 64'(i));
        end
        check("j2_code", 64'(res_code), 64'd0);
        check("j2_elapsed", res_elapsed, 64'd7);
        take_res();

        // Job 3: status stuck RUNNING, watchdog of 20 cycles fires.
        wr0 = wr_cnt; rs0 = reset_cnt; rt0 = restart_cnt;
        stub_run_len = 1000; stub_term = ST_RUNNING; stub_elapsed = 64'd99;
        send_job(10'd0, 9'h000, 32'h0, 32'h0);
        wait_res();
        check("j3_reset_once", 64'(reset_cnt - rs0), 64'd1);
        check("j3_run_cycles", 64'(nop_at_reset), 64'd20);
        check("j3_no_restart", 64'(restart_cnt - rt0), 64'd0);
        check("j3_no_write", 64'(wr_cnt - wr0), 64'd0);
        check("j3_code", 64'(res_code), 64'd3);
        check("j3_elapsed", res_elapsed, 64'd20);
        take_res();

        // Job 4: empty program, ERROR right after RUNNING, result held while res_ready low.
        wr0 = wr_cnt;
        stub_run_len = 1; stub_term = ST_ERROR; stub_elapsed = 64'd3;
        send_job(10'd0, 9'h055, 32'h0, 32'h0);
        wait_res();
        check("j4_no_write", 64'(wr_cnt - wr0), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("j4_hold_valid", {63'd0, res_valid}, 64'd1);
            check("j4_hold_code", 64'(res_code), 64'd2);
            check("j4_hold_elapsed", res_elapsed, 64'd3);
        end
        take_res();

        // Job 5: synchronous reset in the middle of a run.
        st0 = start_bursts;
        stub_run_len = 1000; stub_term = ST_RUNNING;
        send_job(10'd0, 9'h000, 32'h77, 32'h88);
        n = 0;
        while (start_bursts == st0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("j5_start_seen", 64'(start_bursts - st0), 64'd1);
        repeat (6) @(negedge clk);
        check("j5_busy_before_rst", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("j5_rst_cmd", 64'(cmd_register), 64'(CMD_NOP));
        check("j5_rst_busy", {63'd0, busy}, 64'd0);
        check("j5_rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("j5_rst_job_ready", {63'd0, job_ready}, 64'd1);
        check("j5_rst_scc", 64'(start_cc_pointer_register), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Job 6: recovery after reset, single word.
        wr0 = wr_cnt;
        stub_run_len = 2; stub_term = ST_ACCEPTED; stub_elapsed = 64'd5;
        send_job(10'd1, 9'h005, 32'h0, 32'h0);
        put_words(1, 0, 64'h1234);
        wait_res();
        check("j6_wr_count", 64'(wr_cnt - wr0), 64'd1);
        check("j6_wr_addr", 64'(wr_addr_q[wr0]), 64'h5);
        check("j6_code", 64'(res_code), 64'd0);
        check("j6_elapsed", res_elapsed, 64'd5);
        take_res();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
